// File: rtl/fir_seq_pkg.sv
// rtl/fir_seq_pkg.sv - shared types and constants for the FIR tap sequencer
package fir_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        MAC   = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    localparam int MIN_DIV   = 2;
    localparam int OVR_CNT_W = 8;

    // Ratios below MIN_DIV would tick every cycle or never; clamp them up.
    function automatic logic [31:0] clamp_ratio(input logic [31:0] ratio);
        return (ratio < 32'(MIN_DIV)) ? 32'(MIN_DIV) : ratio;
    endfunction

endpackage

// File: rtl/fir_tap_sequencer_sample_tick_gen.sv
// rtl/fir_tap_sequencer_sample_tick_gen.sv - programmable divider producing a registered one-cycle sample_tick
module sample_tick_gen
    import fir_seq_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [DIV_W-1:0] div_ratio,
    output logic             tick_next,
    output logic             sample_tick
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] eff_ratio;
    logic             at_end;

    assign eff_ratio = DIV_W'(clamp_ratio(32'(div_ratio)));

    // >= rather than == so a ratio lowered below the running count ticks at once.
    assign at_end    = (cnt >= (eff_ratio - DIV_W'(1)));
    assign tick_next = enable && at_end;

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            cnt         <= '0;
            sample_tick <= 1'b0;
        end else begin
            sample_tick <= tick_next;
            if (!enable || at_end) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/fir_tap_sequencer.sv
// rtl/fir_tap_sequencer.sv - sample-rate scheduler and tap sequencer for a shared FIR MAC
// Optional saturating overrun counter port enabled by SEQ_OVERRUN_CNT_EN.
module fir_tap_sequencer
    import fir_seq_pkg::*;
#(
    parameter int NUM_TAPS = 16,
    parameter int DIV_W    = 16,
    localparam int ADDR_W  = $clog2(NUM_TAPS)
) (
    input  logic                 clk_in,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic [DIV_W-1:0]     div_ratio,
    output logic                 sample_tick,
    output logic                 shift_en,
    output logic [ADDR_W-1:0]    tap_addr,
    output logic                 acc_clr,
    output logic                 acc_en,
    output logic                 out_valid,
    output logic                 busy,
`ifdef SEQ_OVERRUN_CNT_EN
    output logic [OVR_CNT_W-1:0] overrun_cnt,
`endif
    output logic                 overrun
);

    seq_state_t state;
    logic       tick_next;
    logic       last_tap;

    sample_tick_gen #(
        .DIV_W (DIV_W)
    ) u_tick_gen (
        .clk_in      (clk_in),
        .reset_n     (reset_n),
        .enable      (enable),
        .div_ratio   (div_ratio),
        .tick_next   (tick_next),
        .sample_tick (sample_tick)
    );

    assign last_tap = (tap_addr == ADDR_W'(NUM_TAPS - 1));
    assign busy     = (state != IDLE);

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            tap_addr  <= '0;
            shift_en  <= 1'b0;
            acc_en    <= 1'b0;
            acc_clr   <= 1'b0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            shift_en  <= 1'b0;
            acc_en    <= 1'b0;
            acc_clr   <= 1'b0;
            out_valid <= 1'b0;
            // Registered overrun lines up with the tick it reports: it is set when
            // the next cycle will both carry a tick and be a SHIFT or MAC cycle.
            overrun   <= tick_next && ((state == SHIFT) || ((state == MAC) && !last_tap));
            case (state)
                IDLE: begin
                    if (sample_tick) begin
                        state    <= SHIFT;
                        shift_en <= 1'b1;
                    end
                end
                SHIFT: begin
                    state    <= MAC;
                    tap_addr <= '0;
                    acc_en   <= 1'b1;
                    acc_clr  <= 1'b1;
                end
                MAC: begin
                    if (last_tap) begin
                        state     <= DONE;
                        tap_addr  <= '0;
                        out_valid <= 1'b1;
                    end else begin
                        tap_addr <= tap_addr + ADDR_W'(1);
                        acc_en   <= 1'b1;
                    end
                end
                DONE: begin
                    if (sample_tick) begin
                        state    <= SHIFT;
                        shift_en <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SEQ_OVERRUN_CNT_EN
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            overrun_cnt <= '0;
        end else if (overrun && (overrun_cnt != {OVR_CNT_W{1'b1}})) begin
            overrun_cnt <= overrun_cnt + OVR_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// tb/tb_fir_tap_sequencer.sv - randomized self-checking bench for fir_tap_sequencer against a frame-timing model
module tb_fir_tap_sequencer;

    localparam int NUM_TAPS = 16;
    localparam int DIV_W    = 16;
    localparam int ADDR_W   = $clog2(NUM_TAPS);
    localparam int FRAME    = NUM_TAPS + 2;

    logic              clk_in = 1'b0;
    logic              reset_n;
    logic              enable;
    logic [DIV_W-1:0]  div_ratio;
    logic              sample_tick, shift_en, acc_clr, acc_en, out_valid, busy, overrun;
    logic [ADDR_W-1:0] tap_addr;
`ifdef SEQ_OVERRUN_CNT_EN
    logic [7:0]        overrun_cnt;
`endif

    fir_tap_sequencer #(.NUM_TAPS(NUM_TAPS), .DIV_W(DIV_W)) dut (
        .clk_in      (clk_in),
        .reset_n     (reset_n),
        .enable      (enable),
        .div_ratio   (div_ratio),
        .sample_tick (sample_tick),
        .shift_en    (shift_en),
        .tap_addr    (tap_addr),
        .acc_clr     (acc_clr),
        .acc_en      (acc_en),
        .out_valid   (out_valid),
        .busy        (busy),
`ifdef SEQ_OVERRUN_CNT_EN
        .overrun_cnt (overrun_cnt),
`endif
        .overrun     (overrun)
    );

    always #5 clk_in = ~clk_in;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: divider count, current tick, and the SHIFT cycle of the latest frame.
    int m_cnt   = 0;
    bit m_tick  = 0;
    int cyc     = 0;
    int fstart  = -1000;
    int m_ovr   = 0;
    bit m_ovr_prev = 0;

    task automatic model_reset();
        m_cnt = 0; m_tick = 0; cyc = 0; fstart = -1000; m_ovr = 0; m_ovr_prev = 0;
    endtask

    task automatic check_all();
        bit in_mac, active, exp_ovr;
        int n;
        n       = cyc;
        active  = (n >= fstart) && (n <= fstart + FRAME - 1);
        in_mac  = (n >= fstart + 1) && (n <= fstart + NUM_TAPS);
        exp_ovr = m_tick && (n >= fstart) && (n <= fstart + NUM_TAPS);
        check("sample_tick", 32'(sample_tick), 32'(m_tick));
        check("shift_en",    32'(shift_en),    32'(n == fstart));
        check("acc_en",      32'(acc_en),      32'(in_mac));
        check("acc_clr",     32'(acc_clr),     32'(n == fstart + 1));
        check("tap_addr",    32'(tap_addr),    in_mac ? 32'(n - fstart - 1) : 32'd0);
        check("out_valid",   32'(out_valid),   32'(n == fstart + FRAME - 1));
        check("busy",        32'(busy),        32'(active));
        check("overrun",     32'(overrun),     32'(exp_ovr));
`ifdef SEQ_OVERRUN_CNT_EN
        check("overrun_cnt", 32'(overrun_cnt), 32'(m_ovr));
`endif
        m_ovr_prev = exp_ovr;
    endtask

    task automatic step();
        bit en, prev;
        int r, eff, c;
        en = enable;
        r  = int'(div_ratio);
        @(posedge clk_in);
        #1;
        prev = m_tick;
        c    = cyc;
        eff  = (r < 2) ? 2 : r;
        if (m_ovr_prev && m_ovr < 255) m_ovr++;
        if (!en) begin
            m_cnt = 0; m_tick = 0;
        end else if (m_cnt >= eff - 1) begin
            m_cnt = 0; m_tick = 1;
        end else begin
            m_cnt++; m_tick = 0;
        end
        cyc = c + 1;
        // A tick starts a new frame only from idle or the frame's last (DONE) cycle.
        if (prev && c >= fstart + FRAME - 1) fstart = cyc;
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tick"},  32'(sample_tick), 0);
        check({tag, "_shift"}, 32'(shift_en), 0);
        check({tag, "_addr"},  32'(tap_addr), 0);
        check({tag, "_clr"},   32'(acc_clr), 0);
        check({tag, "_en"},    32'(acc_en), 0);
        check({tag, "_valid"}, 32'(out_valid), 0);
        check({tag, "_busy"},  32'(busy), 0);
        check({tag, "_ovr"},   32'(overrun), 0);
    endtask

    initial begin
        int vcount, waited;
        reset_n   = 1'b0;
        enable    = 1'b0;
        div_ratio = DIV_W'(20);
        repeat (3) @(posedge clk_in);
        #1;
        check_reset_outputs("reset");
        #2;
        reset_n = 1'b1;
        model_reset();

        enable = 1'b1;
        div_ratio = DIV_W'(20); run(200);
        div_ratio = DIV_W'(18); run(200);
        div_ratio = DIV_W'(10); run(200);
        div_ratio = DIV_W'(0);  run(40);
        div_ratio = DIV_W'(1);  run(40);

        // Slow ratio, let the count climb to about 50, then drop to 5.
        div_ratio = DIV_W'(100);
        waited = 0;
        while (!sample_tick && waited < 300) begin step(); waited++; end
        check("wait_tick100", 32'(sample_tick), 1);
        run(51);
        div_ratio = DIV_W'(5);
        step();
        check("ratio_drop_tick", 32'(sample_tick), 1);
        run(30);

        // Drop enable mid-frame at tap 3.
        div_ratio = DIV_W'(20);
        waited = 0;
        while (!(acc_en && tap_addr == ADDR_W'(3)) && waited < 300) begin step(); waited++; end
        check("wait_tap3", 32'(tap_addr), 3);
        enable = 1'b0;
        vcount = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (out_valid) vcount++;
        end
        check("valid_after_disable", 32'(vcount), 1);
        check("idle_after_disable", 32'(busy), 0);

        // Asynchronous reset mid-MAC at tap 7.
        enable = 1'b1;
        waited = 0;
        while (!(acc_en && tap_addr == ADDR_W'(7)) && waited < 300) begin step(); waited++; end
        check("wait_tap7", 32'(tap_addr), 7);
        #1;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(posedge clk_in);
        @(posedge clk_in);
        #3;
        reset_n = 1'b1;
        model_reset();
        run(100);

        // Random ratio and enable changes.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) < 5) div_ratio = DIV_W'($urandom_range(0, 40));
            if ($urandom_range(0, 99) < 3) enable = ~enable;
            step();
        end

        // Fastest ratio: overruns on nearly every tick, enough to saturate the counter.
        enable = 1'b1;
        div_ratio = DIV_W'(2);
        run(800);
`ifdef SEQ_OVERRUN_CNT_EN
        check("overrun_cnt_sat", 32'(overrun_cnt), 255);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
